// File: rtl/p2s_pkg.sv
// Shared defaults and state encoding for the parallel-to-serial converter register.
package p2s_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int NUM_WORDS_DEF = 4;
    localparam int CNT_W_DEF     = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/p2s_shadow_buf.sv
// Single-frame holding register with a full flag; used as the second buffer
// when P2S_DOUBLE_BUF_EN is defined.
module p2s_shadow_buf #(
    parameter int FRAME_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               pop_i,
    input  logic [FRAME_W-1:0] data_i,
    output logic [FRAME_W-1:0] data_o,
    output logic               full_o
);

    logic [FRAME_W-1:0] data_q, data_d;
    logic               full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/p2s_reg.sv
// Parallel-to-serial converter: loads a frame of NUM_WORDS words and emits it
// word 0 first with valid/ready flow control. Macro P2S_DOUBLE_BUF_EN adds a shadow frame.
module p2s_reg
    import p2s_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_WORDS*DATA_W-1:0] parIn,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_W-1:0]           serialOut,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            count,
    output logic                        busy,
    output logic                        done
);

    localparam int              FRAME_W  = NUM_WORDS * DATA_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [DATA_W-1:0]   serial_q, serial_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;
    logic                in_ready_c;
    logic                load;
    logic                beat;
    logic                last_beat;

`ifdef P2S_DOUBLE_BUF_EN
    logic               sh_load;
    logic               sh_pop;
    logic [FRAME_W-1:0] sh_data;
    logic               sh_full;

    p2s_shadow_buf #(
        .FRAME_W (FRAME_W)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .load_i (sh_load),
        .pop_i  (sh_pop),
        .data_i (parIn),
        .data_o (sh_data),
        .full_o (sh_full)
    );
`endif

    assign load      = in_valid & in_ready_c;
    assign beat      = (state_q == SHIFT) & out_ready;
    assign last_beat = beat & (count_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        serial_d   = serial_q;
        count_d    = count_q;
        done_d     = 1'b0;
        in_ready_c = 1'b0;
`ifdef P2S_DOUBLE_BUF_EN
        sh_load    = 1'b0;
        sh_pop     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Gated by rst so in_ready reads low for the whole reset window.
                in_ready_c = start & ~rst;
                if (load) begin
                    frame_d  = parIn;
                    serial_d = parIn[DATA_W-1:0];
                    count_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
`ifdef P2S_DOUBLE_BUF_EN
                in_ready_c = start & ~sh_full & ~rst;
                sh_load    = load & ~last_beat;
`endif
                if (beat) begin
                    if (count_q != LAST_IDX) begin
                        frame_d  = frame_q >> DATA_W;
                        serial_d = frame_q[2*DATA_W-1:DATA_W];
                        count_d  = count_q + CNT_W'(1);
                    end else begin
                        done_d  = 1'b1;
                        count_d = '0;
`ifdef P2S_DOUBLE_BUF_EN
                        if (sh_full) begin
                            sh_pop   = 1'b1;
                            frame_d  = sh_data;
                            serial_d = sh_data[DATA_W-1:0];
                        end else if (load) begin
                            frame_d  = parIn;
                            serial_d = parIn[DATA_W-1:0];
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            frame_q  <= '0;
            serial_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            frame_q  <= frame_d;
            serial_q <= serial_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign serialOut = serial_q;
    assign out_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign count     = count_q;
    assign done      = done_q;

endmodule

// File: tb/tb_p2s_reg.sv
// Directed testbench for p2s_reg; expectations follow P2S_DOUBLE_BUF_EN when defined.
module tb_p2s_reg;

    localparam int DW = 16;
    localparam int NW = 4;
    localparam int CW = 5;
    localparam logic [NW*DW-1:0] F1 = {16'h2000, 16'h1800, 16'h1000, 16'h0800};
    localparam logic [NW*DW-1:0] F2 = {16'h4000, 16'h3800, 16'h3000, 16'h2800};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NW*DW-1:0] parIn = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] serialOut;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;

    p2s_reg #(.DATA_W(DW), .NUM_WORDS(NW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .parIn     (parIn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .serialOut (serialOut),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // obs layout: {serialOut, count, out_valid, busy, done}
    task automatic load_frame(input logic [NW*DW-1:0] f);
        parIn    = f;
        start    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] obs;
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        obs = {serialOut, count, out_valid, busy, done, in_ready};
        n_cmp++;
        if (obs !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, 25'h0);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_in_ready: got %b want 1", in_ready);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] ew [6] = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2000, 16'h2000};
        logic [4:0]  ec [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0};
        logic        eo [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [23:0] obs, exp;
        out_ready = 1'b1;
        load_frame(F1);
        for (int i = 0; i < 6; i++) begin
            obs = {serialOut, count, out_valid, busy, done};
            exp = {ew[i], ec[i], eo[i], eo[i], ed[i]};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL basic_cycle%0d: got %h want %h", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic        rp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] ew [7] = '{16'h1000, 16'h1000, 16'h1000, 16'h1800, 16'h2000, 16'h2000, 16'h2000};
        logic [4:0]  ec [7] = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd3, 5'd3, 5'd0};
        logic        eo [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        ed [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [23:0] obs, exp;
        out_ready = 1'b0;
        load_frame(F1);
        obs = {serialOut, count, out_valid, busy, done};
        exp = {16'h0800, 5'd0, 1'b1, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL stall_first: got %h want %h", obs, exp);
        end
        for (int i = 0; i < 7; i++) begin
            out_ready = rp[i];
            @(negedge clk);
            obs = {serialOut, count, out_valid, busy, done};
            exp = {ew[i], ec[i], eo[i], eo[i], ed[i]};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stall_step%0d: got %h want %h", i, obs, exp);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done_once: got %b want 0", done);
        end
    endtask

    task automatic test_start_gate();
        logic [24:0] obs;
        logic [23:0] o2, e2;
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        parIn    = F2;
        repeat (3) @(negedge clk);
        obs = {serialOut, count, out_valid, busy, done, in_ready};
        n_cmp++;
        if (obs !== 25'h0) begin
            n_fail++;
            $display("FAIL start_low_noload: got %h want %h", obs, 25'h0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        load_frame(F1);
        repeat (2) @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        parIn    = F2;
        @(negedge clk);
        o2 = {serialOut, count, out_valid, busy, done};
        e2 = {16'h2000, 5'd3, 1'b1, 1'b1, 1'b0};
        n_cmp++;
        if (o2 !== e2) begin
            n_fail++;
            $display("FAIL start_drop_word3: got %h want %h", o2, e2);
        end
        @(negedge clk);
        o2 = {serialOut, count, out_valid, busy, done};
        e2 = {16'h2000, 5'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (o2 !== e2) begin
            n_fail++;
            $display("FAIL start_drop_done: got %h want %h", o2, e2);
        end
        repeat (3) @(negedge clk);
        obs = {serialOut, count, out_valid, busy, done, in_ready};
        n_cmp++;
        if (obs !== {16'h2000, 5'd0, 4'b0}) begin
            n_fail++;
            $display("FAIL start_drop_noload: got %h want %h", obs, {16'h2000, 5'd0, 4'b0});
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [23:0] obs, exp;
        out_ready = 1'b1;
        load_frame(F1);
        @(negedge clk);
        n_cmp++;
        if (serialOut !== 16'h1000) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %h want 1000", serialOut);
        end
        #1 rst = 1'b1;
        #1;
        obs = {serialOut, count, out_valid, busy, done};
        n_cmp++;
        if (obs !== 24'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h want %h", obs, 24'h0);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: got %b want 0", done);
        end
        rst = 1'b0;
        load_frame(F2);
        obs = {serialOut, count, out_valid, busy, done};
        exp = {16'h2800, 5'd0, 1'b1, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rstmid_restart: got %h want %h", obs, exp);
        end
        repeat (4) @(negedge clk);
        obs = {serialOut, count, out_valid, busy, done};
        exp = {16'h4000, 5'd0, 1'b0, 1'b0, 1'b1};
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL rstmid_done: got %h want %h", obs, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
`ifdef P2S_DOUBLE_BUF_EN
        int drop = 1;
        logic [15:0] ew [10] = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2800,
                                 16'h3000, 16'h3800, 16'h4000, 16'h4000, 16'h4000};
        logic [4:0]  ec [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0};
        logic        eo [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        ed [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        int drop = 5;
        logic [15:0] ew [10] = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2000,
                                 16'h2800, 16'h3000, 16'h3800, 16'h4000, 16'h4000};
        logic [4:0]  ec [10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
        logic        eo [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        ed [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
        logic [23:0] obs, exp;
        start     = 1'b1;
        out_ready = 1'b1;
        parIn     = F1;
        in_valid  = 1'b1;
        @(negedge clk);
        parIn = F2;
        for (int i = 0; i < 10; i++) begin
            obs = {serialOut, count, out_valid, busy, done};
            exp = {ew[i], ec[i], eo[i], eo[i], ed[i]};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got %h want %h", i, obs, exp);
            end
            if (i == drop) in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_gate();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/p2s_reg.md
Name: p2s_reg

Overview:
- Parallel-to-serial converter register: the transmit-side counterpart of the serial-to-parallel converter register in the baseband modulator datapath.
- Accepts one frame of NUM_WORDS parallel DATA_W-bit samples, e.g. the I/Q symbol pair set.
- Emits the frame one word per accepted beat on a single DATA_W-bit serial word bus.
- Provides valid/ready backpressure, a word index counter and a frame-done pulse.

Parameters:
DATA_W, 16, width of each sample word
NUM_WORDS, 4, words per frame (>=2)
CNT_W, 5, width of count output; must satisfy 2**CNT_W > NUM_WORDS-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  enable; new frames are loaded only while high
parIn  input  NUM_WORDS*DATA_W  frame; word 0 in LSBs, sent first
in_valid  input  1  parIn valid
in_ready  output  1  block can accept a frame
serialOut  output  DATA_W  current serial word (registered)
out_valid  output  1  serialOut valid
out_ready  input  1  downstream accepts serialOut
count  output  CNT_W  index of word on serialOut
busy  output  1  frame in progress (state SHIFT)
done  output  1  one-cycle pulse after last word of a frame is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE, all registers cleared. serialOut=0, out_valid=0, count=0, busy=0, done=0, in_ready=0.
- Handshakes:
  - Frame load = in_valid & in_ready at a rising edge.
  - Output beat = out_valid & out_ready at a rising edge.
- FSM, two states:
  - IDLE:
    - in_ready = start.
    - On load: shift register <= parIn, serialOut <= word 0, count <= 0, out_valid <= 1, go to SHIFT.
    - Latency: word 0 is valid in the cycle after the load edge.
  - SHIFT:
    - in_ready = 0 (macro off), out_valid = 1, busy = 1.
    - On a beat with count < NUM_WORDS-1: count++, serialOut <= word[count+1].
    - On a beat with count == NUM_WORDS-1: done <= 1 for exactly one cycle, out_valid <= 0, count <= 0, serialOut holds its last value, go to IDLE.
- While out_valid=1 and out_ready=0: serialOut and count are held stable; no word is skipped or repeated.
- start deasserted mid-frame: the current frame completes normally and no new frame is loaded. start only gates in_ready.
- Macro off: back-to-back frames have at least one IDLE bubble cycle between the last beat and the next word 0.
- in_valid while in_ready=0: ignored; parIn is not sampled.
- Reset mid-frame: the frame is abandoned, outputs return to reset values immediately, and no done pulse is issued.
- Count wraps only via the explicit clear to 0; it never exceeds NUM_WORDS-1.

Optional Feature:
Macro P2S_DOUBLE_BUF_EN.
- Defined: adds one shadow frame buffer.
  - In SHIFT, in_ready = start & shadow empty, so a frame can load while another is shifting.
  - On the last beat with shadow full: the shadow is moved to the shift register, serialOut <= its word 0, count <= 0, and the FSM stays in SHIFT. done still pulses, giving zero-bubble streaming.
  - Shadow is cleared by reset.
  - A load and the last beat on the same edge: the incoming frame goes directly to the shift register if the shadow is empty.
- Undefined: single buffer, behaviour exactly as in Behaviour.

Decomposition:
- Package p2s_pkg: DATA_W/NUM_WORDS defaults, CNT_W localparam, and the state typedef (IDLE, SHIFT).
- Optional sub-module p2s_shadow_buf: one frame register with full flag and load/pop. It is instantiated only under P2S_DOUBLE_BUF_EN.

Test Plan:
1. Reset then start=1, load parIn words {16'h0800,16'h1000,16'h1800,16'h2000}, out_ready=1 -> serialOut 0800,1000,1800,2000 on 4 consecutive cycles; count 0,1,2,3; done pulses once the following cycle; busy low after.
2. Same frame, out_ready toggled 1,0,0,1,1,0,1 -> each word held stable while stalled; sequence unchanged; done after 4th accepted beat only.
3. start=0 with in_valid=1 -> in_ready=0, no load, outputs at reset values; drop start after 2nd beat of a frame -> frame completes, no further load.
4. Assert rst after 2nd beat (serialOut=1000) -> serialOut=0, out_valid=0, count=0, no done; next frame 16'h2800.. restarts at word 0.
5. Two frames {0800..2000} and {2800,3000,3800,4000} offered back to back, out_ready=1 -> macro off: one idle cycle between 2000 and 2800; macro on: 2800 directly after 2000, two done pulses 4 cycles apart.
